// File: rtl/power_switch_emulator.sv
// Purpose     : emulates per-domain on-chip power switches, answering each request with a delayed ack.
// Latency     : ON_LATENCY / OFF_LATENCY cycles from request sampled to ack change; outputs registered.
// Backpressure: none; requests are level-sensitive and a reversal mid-ramp aborts the ramp.
module power_switch_emulator #(
    parameter int NUM_DOMAINS = 3,
    parameter int ON_LATENCY  = 15,
    parameter int OFF_LATENCY = 15
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_DOMAINS-1:0] switch_n_i,
    output logic [NUM_DOMAINS-1:0] switch_ack_no,
    output logic [NUM_DOMAINS-1:0] busy_o,
    output logic [15:0]            abort_cnt_o
);

    // Ramp counter only ever holds LAT-1 of the longer ramp, so it can never wrap.
    localparam int MAX_LAT = (ON_LATENCY > OFF_LATENCY) ? ON_LATENCY : OFF_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_LATENCY - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_LATENCY - 1);

    // Popcount width and the widened sum used to detect saturation.
    localparam int PC_W  = $clog2(NUM_DOMAINS + 1);
    localparam int SUM_W = 16 + PC_W;

    typedef enum logic [1:0] {
        ST_ON       = 2'd0,
        ST_RAMP_OFF = 2'd1,
        ST_OFF      = 2'd2,
        ST_RAMP_ON  = 2'd3
    } state_t;

    logic [NUM_DOMAINS-1:0] abort_vec;
    logic [PC_W-1:0]        abort_num;
    logic [SUM_W-1:0]       abort_sum;
    logic [15:0]            abort_cnt_q;

    for (genvar d = 0; d < NUM_DOMAINS; d++) begin : g_dom
        state_t           state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             ack_q;
        logic             busy_q;

        // A reversal of the request while ramping is an abort; flagged here for the shared counter.
        assign abort_vec[d] = ((state_q == ST_RAMP_OFF) && !switch_n_i[d]) ||
                              ((state_q == ST_RAMP_ON)  &&  switch_n_i[d]);

        assign switch_ack_no[d] = ack_q;
        assign busy_o[d]        = busy_q;

        // Per-domain switch FSM; abort is tested ahead of ramp completion so a late reversal never acks.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= ST_ON;
                cnt_q   <= '0;
                ack_q   <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_ON: begin
                        if (switch_n_i[d]) begin
                            state_q <= ST_RAMP_OFF;
                            cnt_q   <= OFF_LOAD;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_RAMP_OFF: begin
                        if (!switch_n_i[d]) begin
                            state_q <= ST_ON;
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                        end else if (cnt_q == '0) begin
                            state_q <= ST_OFF;
                            ack_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    ST_OFF: begin
                        if (!switch_n_i[d]) begin
                            state_q <= ST_RAMP_ON;
                            cnt_q   <= ON_LOAD;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_RAMP_ON: begin
                        if (switch_n_i[d]) begin
                            state_q <= ST_OFF;
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                        end else if (cnt_q == '0) begin
                            state_q <= ST_ON;
                            ack_q   <= 1'b0;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_ON;
                        cnt_q   <= '0;
                        ack_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end

`ifndef SYNTHESIS
        // Catch an undriven request while the domain is settled; an X here would silently stall the model.
        always_ff @(posedge clk_i) begin
            if (rst_ni && ((state_q == ST_ON) || (state_q == ST_OFF))) begin
                assert (!$isunknown(switch_n_i[d]));
            end
        end
`endif
    end

    // Number of domains aborting this cycle, added to the count in a widened sum.
    always_comb begin
        abort_num = '0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            abort_num = abort_num + PC_W'(abort_vec[i]);
        end
        abort_sum = SUM_W'(abort_cnt_q) + SUM_W'(abort_num);
    end

    // Saturating abort counter; it sticks at all-ones and only reset clears it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            abort_cnt_q <= '0;
        end else if (|abort_sum[SUM_W-1:16]) begin
            abort_cnt_q <= 16'hFFFF;
        end else begin
            abort_cnt_q <= abort_sum[15:0];
        end
    end

    assign abort_cnt_o = abort_cnt_q;

endmodule
